// File: rtl/period_tick_gen.sv
// Period/tick generator fed by the Nios II period0 PIO export; period updates are shadowed to period boundaries.
// Optional macro PERIOD_GEN_DUTY_EN adds a duty_in port with a programmable high time.
module period_tick_gen #(
    parameter int WIDTH      = 28,
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [WIDTH-1:0] period_in,
`ifdef PERIOD_GEN_DUTY_EN
    input  logic [WIDTH-1:0] duty_in,
`endif
    input  logic             enable,
    input  logic             tick_clr,
    output logic             wave,
    output logic             tick,
    output logic             active,
    output logic [WIDTH-1:0] period_cur,
    output logic [CNT_W-1:0] tick_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [0:0]       state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt, period_nxt, thr_nxt;
    logic             load, boundary;
`ifdef PERIOD_GEN_DUTY_EN
    logic [WIDTH-1:0] duty_cur, duty_nxt;
`endif

    assign load     = enable && (period_in >= WIDTH'(MIN_PERIOD));
    assign boundary = (state == RUN) && (cnt == period_cur - ONE);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        period_nxt = period_cur;
`ifdef PERIOD_GEN_DUTY_EN
        duty_nxt   = duty_cur;
`endif
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt  = RUN;
                    cnt_nxt    = '0;
                    period_nxt = period_in;
`ifdef PERIOD_GEN_DUTY_EN
                    duty_nxt   = duty_in;
`endif
                end
            end
            default: begin
                if (boundary) begin
                    cnt_nxt = '0;
                    if (load) begin
                        period_nxt = period_in;
`ifdef PERIOD_GEN_DUTY_EN
                        duty_nxt   = duty_in;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
        endcase
`ifdef PERIOD_GEN_DUTY_EN
        thr_nxt = duty_nxt;
`else
        thr_nxt = period_nxt >> 1;
`endif
    end

    // Outputs are registered from next-state values so they line up with cnt without combinational decode.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            period_cur <= '0;
`ifdef PERIOD_GEN_DUTY_EN
            duty_cur   <= '0;
`endif
            wave       <= 1'b0;
            tick       <= 1'b0;
            active     <= 1'b0;
            tick_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_cur <= period_nxt;
`ifdef PERIOD_GEN_DUTY_EN
            duty_cur   <= duty_nxt;
`endif
            active     <= (state_nxt == RUN);
            wave       <= (state_nxt == RUN) && (cnt_nxt < thr_nxt);
            tick       <= (state_nxt == RUN) && (cnt_nxt == period_nxt - ONE);
            if (tick_clr)
                tick_count <= boundary ? CNT_W'(1) : '0;
            else if (boundary)
                tick_count <= tick_count + CNT_W'(1);
        end
    end

endmodule
